// File: rtl/riscv_pkg.sv
// Shared RV32M execute-unit types.
// Op encoding follows funct3 of the M extension.
package riscv_pkg;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

endpackage

// File: rtl/muldiv_operand_prep.sv
// Operand conditioning for the iterative mul/div unit:
// signedness, magnitudes, result signs and special-case results.
module muldiv_operand_prep
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] in1,
  input  logic [XLEN-1:0] in2,
  output logic [XLEN-1:0] abs1,
  output logic [XLEN-1:0] abs2,
  output logic [XLEN-1:0] spec_res,
  output logic            qneg,
  output logic            rneg,
  output logic            dz,
  output logic            spec
);

  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

  logic s1;
  logic s2;
  logic n1;
  logic n2;
  logic is_div;
  logic is_rem;
  logic ovf;

  always_comb begin
    s1 = 1'b0;
    s2 = 1'b0;
    unique case (muldiv_op_e'(op))
      MD_MULH, MD_DIV, MD_REM: begin
        s1 = 1'b1;
        s2 = 1'b1;
      end
      MD_MULHSU: s1 = 1'b1;
      default: ;
    endcase
  end

  assign is_div = op[2];
  assign is_rem = op[2] & op[1];
  assign n1     = s1 & in1[XLEN-1];
  assign n2     = s2 & in2[XLEN-1];
  assign abs1   = n1 ? (~in1 + 1'b1) : in1;
  assign abs2   = n2 ? (~in2 + 1'b1) : in2;
  assign qneg   = n1 ^ n2;
  assign rneg   = n1;

  // s1 together with is_div means DIV or REM
  assign dz   = is_div & ~|in2;
  assign ovf  = s1 & is_div & (in1 == MIN) & (&in2);
  assign spec = dz | ovf;

  always_comb begin
    spec_res = '0;
    if (dz)
      spec_res = is_rem ? in1 : '1;
    else
      spec_res = is_rem ? '0 : MIN;
  end

endmodule

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle RV32M unit: radix-2 shift-add multiply and
// restoring divide sharing one XLEN+1 adder.
module alu_muldiv_seq
  import riscv_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter bit FAST_SPECIAL = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] in1,
  input  logic [XLEN-1:0] in2,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic            zero,
  output logic            negative,
  output logic            div_by_zero
);

  localparam int CW = $clog2(XLEN);

  md_state_e       state_q;
  md_state_e       state_d;
  logic [2:0]      op_q;
  logic [XLEN-1:0] acc_q;
  logic [XLEN-1:0] mq_q;
  logic [XLEN-1:0] b_q;
  logic [XLEN-1:0] spec_res_q;
  logic            qneg_q;
  logic            rneg_q;
  logic            spec_q;
  logic            dz_q;
  logic [CW-1:0]   cnt_q;
  logic            done_q;
  logic [XLEN-1:0] res_q;
  logic            dz_out_q;

  logic [XLEN-1:0] p_abs1;
  logic [XLEN-1:0] p_abs2;
  logic [XLEN-1:0] p_spec_res;
  logic            p_qneg;
  logic            p_rneg;
  logic            p_dz;
  logic            p_spec;
  logic            accept;

  muldiv_operand_prep #(
    .XLEN(XLEN)
  ) u_prep (
    .op      (op_i),
    .in1     (in1),
    .in2     (in2),
    .abs1    (p_abs1),
    .abs2    (p_abs2),
    .spec_res(p_spec_res),
    .qneg    (p_qneg),
    .rneg    (p_rneg),
    .dz      (p_dz),
    .spec    (p_spec)
  );

  // The done_o cycle is not an accept slot either
  assign accept = start_i & ~flush_i & ~done_q
                & (state_q == MD_IDLE);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      MD_IDLE: begin
        if (accept)
          state_d = (FAST_SPECIAL && p_spec)
                  ? MD_DONE : MD_CALC;
      end
      MD_CALC: begin
        if (cnt_q == '0)
          state_d = MD_DONE;
      end
      MD_DONE: state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
    if (flush_i)
      state_d = MD_IDLE;
  end

  logic [XLEN:0]   add_x;
  logic [XLEN:0]   add_y;
  logic            add_ci;
  logic [XLEN+1:0] add_s;
  logic [XLEN:0]   rem_sh;
  logic            nb;
  logic [XLEN-1:0] acc_n;
  logic [XLEN-1:0] mq_n;

  assign rem_sh = {acc_q, mq_q[XLEN-1]};
  assign add_s  = {1'b0, add_x} + {1'b0, add_y}
                + {{(XLEN+1){1'b0}}, add_ci};
  assign nb     = add_s[XLEN+1];

  always_comb begin
    add_x  = {1'b0, acc_q};
    add_y  = mq_q[0] ? {1'b0, b_q} : '0;
    add_ci = 1'b0;
    acc_n  = add_s[XLEN:1];
    mq_n   = {add_s[0], mq_q[XLEN-1:1]};
    if (op_q[2]) begin
      add_x  = rem_sh;
      add_y  = ~{1'b0, b_q};
      add_ci = 1'b1;
      acc_n  = nb ? add_s[XLEN-1:0] : rem_sh[XLEN-1:0];
      mq_n   = {mq_q[XLEN-2:0], nb};
    end
  end

  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s;
  logic [XLEN-1:0]   rem_s;
  logic [XLEN-1:0]   fix;
  logic              l_sel;
  logic              h_sel;
  logic              q_sel;
  logic              r_sel;

  assign prod   = {acc_q, mq_q};
  assign prod_s = qneg_q ? (~prod + 1'b1) : prod;
  assign quo_s  = qneg_q ? (~mq_q + 1'b1) : mq_q;
  assign rem_s  = rneg_q ? (~acc_q + 1'b1) : acc_q;

  assign l_sel = ~spec_q & ~op_q[2] & (op_q[1:0] == 2'd0);
  assign h_sel = ~spec_q & ~op_q[2] & (op_q[1:0] != 2'd0);
  assign q_sel = ~spec_q & op_q[2] & ~op_q[1];
  assign r_sel = ~spec_q & op_q[2] & op_q[1];

  always_comb begin
    fix = '0;
    unique case (1'b1)
      spec_q: fix = spec_res_q;
      l_sel:  fix = prod_s[XLEN-1:0];
      h_sel:  fix = prod_s[2*XLEN-1:XLEN];
      q_sel:  fix = quo_s;
      r_sel:  fix = rem_s;
      default: fix = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= MD_IDLE;
      op_q       <= 3'd0;
      acc_q      <= '0;
      mq_q       <= '0;
      b_q        <= '0;
      spec_res_q <= '0;
      qneg_q     <= 1'b0;
      rneg_q     <= 1'b0;
      spec_q     <= 1'b0;
      dz_q       <= 1'b0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      res_q      <= '0;
      dz_out_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      if (accept) begin
        op_q       <= op_i;
        acc_q      <= '0;
        mq_q       <= p_abs1;
        b_q        <= p_abs2;
        spec_res_q <= p_spec_res;
        qneg_q     <= p_qneg;
        rneg_q     <= p_rneg;
        spec_q     <= p_spec;
        dz_q       <= p_dz;
        cnt_q      <= CW'(XLEN-1);
      end else if (state_q == MD_CALC && !flush_i) begin
        acc_q <= acc_n;
        mq_q  <= mq_n;
        cnt_q <= cnt_q - 1'b1;
      end else if (state_q == MD_DONE && !flush_i) begin
        res_q    <= fix;
        dz_out_q <= dz_q;
        done_q   <= 1'b1;
      end
    end
  end

  assign busy_o      = (state_q != MD_IDLE);
  assign done_o      = done_q;
  assign result_o    = res_q;
  assign zero        = (res_q == '0);
  assign negative    = res_q[XLEN-1];
  assign div_by_zero = dz_out_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed bench for alu_muldiv_seq: RV32M results,
// latency, specials, flush, async reset, start while busy.
module tb_alu_muldiv_seq;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [2:0]  op_i = 3'd0;
  logic [31:0] in1 = '0;
  logic [31:0] in2 = '0;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;
  logic        zero;
  logic        negative;
  logic        div_by_zero;

  int n_run  = 0;
  int n_fail = 0;
  int n_done = 0;

  alu_muldiv_seq #(
    .XLEN(32),
    .FAST_SPECIAL(1'b1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .op_i       (op_i),
    .in1        (in1),
    .in2        (in2),
    .flush_i    (flush_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .result_o   (result_o),
    .zero       (zero),
    .negative   (negative),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (done_o) n_done++;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!done_o && lat < 60) begin
      @(posedge clk);
      lat++;
      #1;
    end
  endtask

  task automatic run(input string tag,
                     input muldiv_op_e op,
                     input logic [31:0] a,
                     input logic [31:0] b,
                     input int exp_lat,
                     input logic [31:0] exp_res,
                     input logic exp_dz);
    int lat;
    @(negedge clk);
    start_i = 1'b1;
    op_i    = op;
    in1     = a;
    in2     = b;
    @(posedge clk);
    #1 start_i = 1'b0;
    chk({tag, "_busy"}, 32'(busy_o), 32'd1);
    wait_done(lat);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_res"}, result_o, exp_res);
    chk({tag, "_dz"}, 32'(div_by_zero), 32'(exp_dz));
    chk({tag, "_zero"}, 32'(zero), 32'(exp_res == 0));
    chk({tag, "_neg"}, 32'(negative), 32'(exp_res[31]));
    @(posedge clk);
    #1;
    chk({tag, "_pulse"}, 32'(done_o), 32'd0);
    chk({tag, "_hold"}, result_o, exp_res);
  endtask

  initial begin
    int lat;
    int d0;
    #2;
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_res", result_o, 32'd0);
    chk("rst_zero", 32'(zero), 32'd1);
    chk("rst_neg", 32'(negative), 32'd0);
    chk("rst_dz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run("mul", MD_MUL, 32'd7, 32'hFFFF_FFFD, 33, 32'hFFFF_FFEB, 1'b0);
    run("mulh", MD_MULH, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h0, 1'b0);
    run("mulhsu", MD_MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000, 1'b0);
    run("mulhu", MD_MULHU, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h7FFF_FFFF, 1'b0);
    run("mulh_nn", MD_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'h0, 1'b0);
    run("mul_big", MD_MUL, 32'h0001_0000, 32'h0001_0000, 33, 32'h0, 1'b0);
    run("div", MD_DIV, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD, 1'b0);
    run("rem", MD_REM, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 1'b0);
    run("div_pn", MD_DIV, 32'd7, 32'hFFFF_FFFE, 33, 32'hFFFF_FFFD, 1'b0);
    run("rem_pn", MD_REM, 32'd7, 32'hFFFF_FFFE, 33, 32'd1, 1'b0);
    run("div0", MD_DIV, 32'd5, 32'd0, 1, 32'hFFFF_FFFF, 1'b1);
    run("divu0", MD_DIVU, 32'd5, 32'd0, 1, 32'hFFFF_FFFF, 1'b1);
    run("rem0", MD_REM, 32'hFFFF_FFF9, 32'd0, 1, 32'hFFFF_FFF9, 1'b1);
    run("divovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, 1'b0);
    run("removf", MD_REM, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h0, 1'b0);
    run("divu_big", MD_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h0, 1'b0);
    run("divu", MD_DIVU, 32'd100, 32'd7, 33, 32'd14, 1'b0);
    run("remu", MD_REMU, 32'd100, 32'd7, 33, 32'd2, 1'b0);

    // flush a DIV in flight, then start a MUL right after
    d0 = n_done;
    @(negedge clk);
    start_i = 1'b1;
    op_i = MD_DIV;
    in1 = 32'd100;
    in2 = 32'd7;
    @(posedge clk);
    #1 start_i = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush_i = 1'b1;
    @(posedge clk);
    #1 flush_i = 1'b0;
    chk("flush_busy", 32'(busy_o), 32'd0);
    chk("flush_res", result_o, 32'd2);
    start_i = 1'b1;
    op_i = MD_MUL;
    in1 = 32'd3;
    in2 = 32'd4;
    @(posedge clk);
    #1 start_i = 1'b0;
    wait_done(lat);
    chk("flush_lat", lat, 33);
    chk("flush_mul", result_o, 32'd12);
    chk("flush_ndone", n_done - d0, 0);
    repeat (3) @(posedge clk);
    #1 chk("flush_ndone2", n_done - d0, 1);

    // async reset in the middle of CALC
    @(negedge clk);
    start_i = 1'b1;
    op_i = MD_MUL;
    in1 = 32'd7;
    in2 = 32'd9;
    @(posedge clk);
    #1 start_i = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy_o), 32'd0);
    chk("arst_res", result_o, 32'd0);
    chk("arst_zero", 32'(zero), 32'd1);
    chk("arst_done", 32'(done_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    d0 = n_done;
    repeat (40) @(posedge clk);
    #1 chk("arst_nodone", n_done - d0, 0);
    chk("arst_res2", result_o, 32'd0);

    // start held high while busy gives a single completion
    @(negedge clk);
    d0 = n_done;
    start_i = 1'b1;
    op_i = MD_MUL;
    in1 = 32'd6;
    in2 = 32'd7;
    @(posedge clk);
    #1 in1 = 32'd100;
    wait_done(lat);
    start_i = 1'b0;
    chk("held_lat", lat, 33);
    chk("held_res", result_o, 32'd42);
    repeat (40) @(posedge clk);
    #1;
    chk("held_ndone", n_done - d0, 1);
    chk("held_busy", 32'(busy_o), 32'd0);
    chk("held_res2", result_o, 32'd42);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
